// File: rtl/swi_event_reader.sv
// Switch-bank reader: two-flop synchronizer, per-bit debounce, rise/fall pulses and an event FIFO.
// Optional macro SWI_READER_DROP_CNT_EN enables the saturating dropped-event counter on drop_cnt.
module swi_event_reader #(
    parameter int NBITS      = 8,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_2,
    input  logic                        reset,
    input  logic [NBITS-1:0]            SWI,
    output logic [NBITS-1:0]            sw_stable,
    output logic [NBITS-1:0]            sw_rise,
    output logic [NBITS-1:0]            sw_fall,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [NBITS-1:0]            evt_mask,
    output logic [NBITS-1:0]            evt_value,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        evt_ovf,
    input  logic                        ovf_clr,
    output logic [7:0]                  drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    DB_LAST    = 8'(DEBOUNCE - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [NBITS-1:0]   sync1_q;
    logic [NBITS-1:0]   sync2_q;
    logic [NBITS-1:0]   stable_q;
    logic [NBITS-1:0]   stable_d;
    logic [NBITS-1:0]   rise_q;
    logic [NBITS-1:0]   fall_q;
    logic [NBITS*8-1:0] cnt_q;
    logic [NBITS*8-1:0] cnt_d;

    logic [2*NBITS-1:0] mem_q [FIFO_DEPTH];
    logic [2*NBITS-1:0] head;
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      rd_ptr_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               push;
    logic               pop;
    logic               full;
    logic               drop;
    logic               accept;

    // Per-bit debounce: a bit flips only after sync2 has disagreed with it for DEBOUNCE cycles.
    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_debounce
            logic differs;
            logic expired;
            assign differs = (sync2_q[gi] != stable_q[gi]);
            assign expired = (cnt_q[gi*8 +: 8] == DB_LAST);
            assign cnt_d[gi*8 +: 8] = (!differs || expired) ? 8'd0 : cnt_q[gi*8 +: 8] + 8'd1;
            assign stable_d[gi]     = (differs && expired) ? ~stable_q[gi] : stable_q[gi];
        end
    endgenerate

    always_comb begin
        push     = (stable_d != stable_q);
        pop      = (count_q != '0) && evt_ready;
        full     = (count_q == FULL_COUNT);
        drop     = push && full && !pop;
        accept   = push && !drop;
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q  <= SWI;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= {stable_q ^ stable_d, stable_d};
            end
        end
    end

`ifdef SWI_READER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

    assign head      = mem_q[rd_ptr_q];
    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;
    assign evt_valid = (count_q != '0);
    assign evt_mask  = evt_valid ? head[2*NBITS-1:NBITS] : '0;
    assign evt_value = evt_valid ? head[NBITS-1:0] : '0;
    assign evt_count = count_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: doc/swi_event_reader.md
Name: swi_event_reader

Overview:
- Input-side counterpart to the panel output logic: reads the SWI switch bank instead of driving LED/SEG.
- Synchronizes and debounces each switch bit, and produces single-cycle rise/fall pulses.
- Queues every change of the debounced bank as an event in a small FIFO, read out through a valid/ready handshake.
- Consumers are the exercise logic inside top and any sequential controllers that need clean switch edges.

Parameters:
- NBITS, 8, switch bank width (matches NBITS_TOP)
- DEBOUNCE, 4, consecutive stable cycles required before a bit change is accepted; range 1..255
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2

Ports:
- clk_2  in  1  system clock
- reset  in  1  synchronous, active-high reset
- SWI  in  NBITS  raw asynchronous switch inputs
- sw_stable  out  NBITS  debounced switch state
- sw_rise  out  NBITS  one-cycle pulse per bit on a debounced 0->1 change
- sw_fall  out  NBITS  one-cycle pulse per bit on a debounced 1->0 change
- evt_valid  out  1  FIFO head entry is valid
- evt_ready  in  1  consumer accepts the head entry
- evt_mask  out  NBITS  head entry: bits that changed
- evt_value  out  NBITS  head entry: sw_stable value after the change
- evt_count  out  $clog2(FIFO_DEPTH)+1  entries currently held
- evt_ovf  out  1  sticky flag: an event was dropped
- ovf_clr  in  1  clears evt_ovf
- drop_cnt  out  8  dropped-event counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_2; reset is synchronous and active-high.
- Reset: every register and output is 0, including both sync stages, debounce counters, sw_stable, pulses, FIFO pointers, evt_count, evt_ovf and drop_cnt.
- Synchronizer: two flops per bit (sync1, sync2). The only logic that uses sync2 is the debounce logic.
- Debounce, per bit, with an 8-bit counter cnt:
  - if sync2 == sw_stable: cnt <= 0.
  - else if cnt == DEBOUNCE-1: sw_stable toggles and cnt <= 0.
  - else: cnt <= cnt+1.
- Debounce latency: a SWI step held steady appears on sw_stable exactly DEBOUNCE+2 rising edges after it is applied.
- Glitch rejection: a glitch shorter than DEBOUNCE cycles at sync2 never reaches sw_stable.
- Pulses: sw_rise and sw_fall are registered in the same cycle sw_stable updates and last exactly one cycle. Several bits may pulse at once.
- Event generation:
  - In any cycle where the next sw_stable differs from the current one, push one entry: mask = old XOR new, value = new.
  - At most one push per cycle, even when several bits change together.
- FIFO:
  - Circular buffer with wrap-around read and write pointers.
  - evt_valid = (evt_count != 0).
  - evt_mask and evt_value show the head entry, and are 0 when the FIFO is empty.
  - Pop when evt_valid && evt_ready. evt_ready while empty is ignored.
  - Push while not full: accepted.
  - Push while full with no pop: entry dropped, evt_ovf <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both take effect and evt_count is unchanged.
  - Push and pop in the same cycle while empty is impossible, because a pop requires evt_valid.
  - Push and pop in the same cycle otherwise: evt_count is unchanged.
- evt_ovf: set by a drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, the set wins.
- Reset mid-operation: FIFO contents are discarded and sw_stable returns to 0. If SWI is nonzero after reset is released, events are generated for those bits DEBOUNCE+2 cycles later.

Optional Feature:
- Macro: SWI_READER_DROP_CNT_EN.
- Defined:
  - drop_cnt is an 8-bit counter incremented on each dropped event, saturating at 255.
  - ovf_clr also clears drop_cnt.
  - A drop and ovf_clr in the same cycle give drop_cnt = 1.
- Undefined: drop_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset release with SWI=8'h00, then SWI=8'h05 held -> at edge DEBOUNCE+2 (6): sw_stable=8'h05, sw_rise=8'h05 for one cycle, evt_valid=1, evt_mask=8'h05, evt_value=8'h05, evt_count=1.
- SWI bit 3 toggled high for 3 cycles with DEBOUNCE=4 -> sw_stable stays 8'h00, no pulses, evt_count stays 0.
- evt_ready held 0; five separate debounced changes on bit 0 (0->1->0->1->0->1) -> evt_count=4 and evt_ovf=1. With the macro, drop_cnt=1. Head entry is mask=8'h01, value=8'h01.
- FIFO full, evt_ready=1 in the same cycle as a new change -> no drop, evt_count stays 4, head advances to the second entry (mask=8'h01, value=8'h00).
- Drain all entries with evt_ready=1 -> evt_valid=0, evt_mask=evt_value=8'h00. Then pulse ovf_clr -> evt_ovf=0 and drop_cnt=0.
- Reset asserted with 2 entries queued and SWI=8'hFF -> next cycle all outputs 0. After release, sw_stable=8'hFF at edge 6 and a single event is queued with mask=8'hFF, value=8'hFF.
